// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states, default width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; drive neg with the sign bit to get an absolute value.
// Latency: combinational.
// Backpressure: none.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] dIn,
  input  logic         neg,
  output logic [W-1:0] dOut
);

  // negate when requested, pass through otherwise
  always_comb begin
    dOut = dIn;
    if (neg) dOut = ~dIn + 1'b1;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide (signed and unsigned) with HI/LO result registers.
// Latency: WIDTH CALC cycles + 1 FIX cycle, result in DONE; zero-operand shortcut when MULDIV_ZERO_BYPASS_EN is defined.
// Backpressure: busy stalls the pipeline during CALC/FIX; start is ignored there, flush aborts.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state, stateNext;
  logic   accept;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] accHi;   // product high half / partial remainder
  logic [WIDTH-1:0] accLo;   // multiplier then product low half / dividend then quotient
  logic [WIDTH-1:0] opB;     // multiplicand or divisor magnitude
  logic             isDiv;
  logic             negLo;   // negate product (mult) or quotient (div) in FIX
  logic             negHi;   // negate remainder in FIX
  logic             divZero;

  op_e opIn;
  logic opDiv, opSigned, aNeg, bNeg, bZero, bypass;
  logic [WIDTH-1:0] magA, magB;

  assign opIn     = op_e'(op);
  assign opDiv    = (opIn == OP_DIV) || (opIn == OP_DIVU);
  assign opSigned = (opIn == OP_MULT) || (opIn == OP_DIV);
  assign aNeg     = opSigned & a[WIDTH-1];
  assign bNeg     = opSigned & b[WIDTH-1];
  assign bZero    = (b == '0);

`ifdef MULDIV_ZERO_BYPASS_EN
  logic aZero;
  assign aZero  = (a == '0);
  assign bypass = opDiv ? (aZero & ~bZero) : (aZero | bZero);
`else
  assign bypass = 1'b0;
`endif

  muldiv_signfix #(.W(WIDTH)) uAbsA (.dIn(a), .neg(aNeg), .dOut(magA));
  muldiv_signfix #(.W(WIDTH)) uAbsB (.dIn(b), .neg(bNeg), .dOut(magB));

  // sign correction applied in FIX
  logic [2*WIDTH-1:0] fixProd;
  logic [WIDTH-1:0]   fixQ, fixR;

  muldiv_signfix #(.W(2*WIDTH)) uFixP (.dIn({accHi, accLo}), .neg(negLo), .dOut(fixProd));
  muldiv_signfix #(.W(WIDTH))   uFixQ (.dIn(accLo), .neg(negLo), .dOut(fixQ));
  muldiv_signfix #(.W(WIDTH))   uFixR (.dIn(accHi), .neg(negHi), .dOut(fixR));

  // one iteration step of each algorithm
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             divFit;

  assign sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
  assign shifted = {accHi, accLo[WIDTH-1]};
  assign divFit  = (shifted >= {1'b0, opB});
  assign trial   = shifted[WIDTH-1:0] - opB;

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  // next-state logic; flush wins over start, start only honoured in IDLE/DONE
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        stateNext = S_IDLE;
        if (start) begin
          accept    = 1'b1;
          stateNext = bypass ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush)            stateNext = S_IDLE;
        else if (cnt == LAST) stateNext = S_FIX;
      end
      S_FIX:   stateNext = flush ? S_IDLE : S_DONE;
      default: stateNext = S_IDLE;
    endcase
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opB     <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      dz      <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      isDiv   <= opDiv;
      divZero <= opDiv & bZero;
      negLo   <= (aNeg ^ bNeg) & ~(opDiv & bZero);
      negHi   <= opDiv & aNeg & ~bZero;
      accHi   <= '0;
      // zero divisor: run the raw dividend through so the remainder ends up equal to a
      accLo   <= (opDiv & bZero) ? a : magA;
      opB     <= magB;
      if (bypass) begin
        hi <= '0;
        lo <= '0;
        dz <= 1'b0;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      if (isDiv) begin
        accHi <= divFit ? trial : shifted[WIDTH-1:0];
        accLo <= {accLo[WIDTH-2:0], divFit};
      end else begin
        accHi <= sum[WIDTH:1];
        accLo <= {sum[0], accLo[WIDTH-1:1]};
      end
    end else if ((state == S_FIX) && !flush) begin
      dz <= divZero;
      if (isDiv) begin
        lo <= fixQ;
        hi <= fixR;
      end else begin
        {hi, lo} <= fixProd;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a behavioural model, scoreboard-ordered.
// Latency: checks WIDTH+2 result latency (1 with MULDIV_ZERO_BYPASS_EN for zero operands).
// Backpressure: checks busy during the operation, start ignored while busy, flush abort.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int nTests = 0;
  int nFail  = 0;
  logic [2*W:0] sb[$];   // {hi, lo, dz}

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, sp;
    logic [2*W-1:0] p;
    int qi, ri;
    case (o)
      2'b00: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sp = sx * sy;
        return {sp, 1'b0};
      end
      2'b01: begin
        p = {32'h0, x} * {32'h0, y};
        return {p, 1'b0};
      end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF, 1'b1};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000, 1'b0};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {ri, qi, 1'b0};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF, 1'b1};
        return {x % y, x / y, 1'b0};
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULDIV_ZERO_BYPASS_EN
    if (o[1] ? (x == 0 && y != 0) : (x == 0 || y == 0)) return 1;
`endif
    return W + 2;
  endfunction

  // issue one op, wait for done, compare latency, busy profile and results
  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W:0] exp, input int pokeAt, input string tag);
    int lat;
    int want;
    bit busyOk;
    logic [2*W:0] e;
    want = expLatency(o, x, y);
    @(negedge clk);
    rst = 1'b0; op = o; a = x; b = y; start = 1'b1;
    sb.push_back(exp);
    lat = 0;
    busyOk = 1'b1;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busyOk = 1'b0;
      if (lat == pokeAt) begin
        start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
      end
    end
    check({tag, "/latency"}, 65'(lat), 65'(want));
    check({tag, "/busy_during"}, 65'(busyOk), 65'(1));
    check({tag, "/busy_at_done"}, 65'(busy), 65'(0));
    e = sb.pop_front();
    check({tag, "/hi"}, 65'(hi), 65'(e[2*W:W+1]));
    check({tag, "/lo"}, 65'(lo), 65'(e[W:1]));
    check({tag, "/dz"}, 65'(dz), 65'(e[0]));
    @(negedge clk);
    check({tag, "/done_pulse"}, 65'(done), 65'(0));
  endtask

  initial begin
    bit seen;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    // reset state
    repeat (2) @(negedge clk);
    check("rst/busy", 65'(busy), 65'(0));
    check("rst/done", 65'(done), 65'(0));
    check("rst/hi", 65'(hi), 65'(0));
    check("rst/lo", 65'(lo), 65'(0));
    check("rst/dz", 65'(dz), 65'(0));

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}, 0, "multu_max");
    runOp(2'b00, 32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}, 0, "mult_neg");
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 0, "div_neg");
    runOp(2'b11, 32'd5, 32'd0,                 {32'h0000_0005, 32'hFFFF_FFFF, 1'b1}, 0, "divu_zero");
    runOp(2'b11, 32'd9, 32'd4,                 {32'h0000_0001, 32'h0000_0002, 1'b0}, 3, "divu_9_4");

    // flush on the 10th CALC cycle, start in the same cycle
    @(negedge clk);
    op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_1234; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush/busy", 65'(busy), 65'(0));
    check("flush/done", 65'(done), 65'(0));
    check("flush/hi", 65'(hi), 65'(1));
    check("flush/lo", 65'(lo), 65'(2));
    check("flush/dz", 65'(dz), 65'(0));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("flush/no_activity", 65'(seen), 65'(0));

    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000, 1'b0}, 0, "div_min_m1");

    // reset in the middle of CALC, start held during reset
    @(negedge clk);
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst/busy", 65'(busy), 65'(0));
    check("midrst/done", 65'(done), 65'(0));
    check("midrst/hi", 65'(hi), 65'(0));
    check("midrst/lo", 65'(lo), 65'(0));
    check("midrst/dz", 65'(dz), 65'(0));
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    repeat (2) @(negedge clk);
    check("rsthold/busy", 65'(busy), 65'(0));
    runOp(2'b01, 32'd6, 32'd7, model(2'b01, 32'd6, 32'd7), 0, "after_rst");

    // random operations against the model
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      runOp(ro, ra, rb, model(ro, ra, rb), 0, $sformatf("rand%0d", i));
    end

    // zero-operand multiply (shortcut only when the bypass is built in)
    runOp(2'b00, 32'd0, 32'd5, {32'h0, 32'h0, 1'b0}, 0, "mult_zero");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
